// File: rtl/sc_point_pkg.sv
// Shared constants for the point/car datapath: shift codes, WAIT FSM states, default patterns.
package sc_point_pkg;

    localparam logic [1:0] SHIFT_LEFT  = 2'b01;
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;
    localparam logic [1:0] SHIFT_HOLD  = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } wait_state_t;

    localparam logic [7:0] DEF_INIT_POS    = 8'b0001_0000;
    localparam logic [7:0] DEF_CAR_PATTERN = 8'b0001_1000;

endpackage

// File: rtl/sc_point_prescaler.sv
// Mod-TICK_MAX move prescaler; registered active-low tick one cycle after the wrapping strobe.
// Clear is synchronous and wins over a same-cycle strobe, suppressing the tick.
module sc_point_prescaler #(
    parameter int TICK_MAX = 25,
    localparam int CW = (TICK_MAX > 2) ? $clog2(TICK_MAX) : 1
) (
    input  logic SC_STATEMACHINEPOINT_CLOCK_50,
    input  logic SC_STATEMACHINEPOINT_RESET_InHigh,
    input  logic clear,
    input  logic upcount,
    output logic tick_n
);

    logic [CW-1:0] count;

    always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
        if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
            count  <= '0;
            tick_n <= 1'b1;
        end else if (clear) begin
            count  <= '0;
            tick_n <= 1'b1;
        end else if (upcount) begin
            if (count == CW'(TICK_MAX - 1)) begin
                count  <= '0;
                tick_n <= 1'b0;
            end else begin
                count  <= count + 1'b1;
                tick_n <= 1'b1;
            end
        end else begin
            tick_n <= 1'b1;
        end
    end

endmodule

// File: rtl/sc_point_datapath.sv
// Point/car datapath: position shift register, saturating score, WAIT hold FSM, move prescaler.
// Optional SC_POINT_WRAP_EN turns the saturating shifts into rotates.
module sc_point_datapath
    import sc_point_pkg::*;
#(
    parameter int                       DATAWIDTH   = 8,
    parameter logic [DATAWIDTH-1:0]     INIT_POS    = DATAWIDTH'(DEF_INIT_POS),
    parameter logic [DATAWIDTH-1:0]     CAR_PATTERN = DATAWIDTH'(DEF_CAR_PATTERN),
    parameter int                       TICK_MAX    = 25,
    parameter int                       WAIT_CYCLES = 4,
    parameter int                       SCOREWIDTH  = 4
) (
    input  logic                  SC_STATEMACHINEPOINT_CLOCK_50,
    input  logic                  SC_STATEMACHINEPOINT_RESET_InHigh,
    input  logic                  SC_POINT_clear_InLow,
    input  logic                  SC_POINT_load0_InLow,
    input  logic                  SC_POINT_POINTselection_In,
    input  logic [1:0]            SC_POINT_shiftselection_In,
    input  logic                  SC_POINT_upcount_InLow,
    input  logic [DATAWIDTH-1:0]  SC_POINT_data_In,
    output logic [DATAWIDTH-1:0]  SC_POINT_point_Out,
    output logic [SCOREWIDTH-1:0] SC_POINT_score_Out,
    output logic                  SC_POINT_T0_OutLow,
    output logic                  SC_POINT_WAIT_Out
);

    localparam int WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    logic          clear;
    logic          load;
    wait_state_t   state;
    logic [WW-1:0] wait_cnt;

    assign clear = ~SC_POINT_clear_InLow;
    assign load  = ~SC_POINT_load0_InLow;

    sc_point_prescaler #(
        .TICK_MAX (TICK_MAX)
    ) u_prescaler (
        .SC_STATEMACHINEPOINT_CLOCK_50     (SC_STATEMACHINEPOINT_CLOCK_50),
        .SC_STATEMACHINEPOINT_RESET_InHigh (SC_STATEMACHINEPOINT_RESET_InHigh),
        .clear                             (clear),
        .upcount                           (~SC_POINT_upcount_InLow),
        .tick_n                            (SC_POINT_T0_OutLow)
    );

    // Priority clear > load > shift > hold; shifts at an edge either saturate or rotate.
    always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
        if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
            SC_POINT_point_Out <= INIT_POS;
        end else if (clear) begin
            SC_POINT_point_Out <= INIT_POS;
        end else if (load) begin
            SC_POINT_point_Out <= SC_POINT_POINTselection_In ? CAR_PATTERN : SC_POINT_data_In;
        end else begin
            case (SC_POINT_shiftselection_In)
                SHIFT_LEFT: begin
`ifdef SC_POINT_WRAP_EN
                    SC_POINT_point_Out <= {SC_POINT_point_Out[DATAWIDTH-2:0], SC_POINT_point_Out[DATAWIDTH-1]};
`else
                    if (!SC_POINT_point_Out[DATAWIDTH-1])
                        SC_POINT_point_Out <= {SC_POINT_point_Out[DATAWIDTH-2:0], 1'b0};
`endif
                end
                SHIFT_RIGHT: begin
`ifdef SC_POINT_WRAP_EN
                    SC_POINT_point_Out <= {SC_POINT_point_Out[0], SC_POINT_point_Out[DATAWIDTH-1:1]};
`else
                    if (!SC_POINT_point_Out[0])
                        SC_POINT_point_Out <= {1'b0, SC_POINT_point_Out[DATAWIDTH-1:1]};
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
        if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
            SC_POINT_score_Out <= '0;
        end else if (clear) begin
            SC_POINT_score_Out <= '0;
        end else if (load && SC_POINT_POINTselection_In && (SC_POINT_score_Out != '1)) begin
            SC_POINT_score_Out <= SC_POINT_score_Out + 1'b1;
        end
    end

    // WAIT stays high for WAIT_CYCLES cycles: the load cycle's edge plus WAIT_CYCLES-1 countdown steps.
    always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
        if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
            state             <= IDLE;
            wait_cnt          <= '0;
            SC_POINT_WAIT_Out <= 1'b0;
        end else if (clear) begin
            state             <= IDLE;
            wait_cnt          <= '0;
            SC_POINT_WAIT_Out <= 1'b0;
        end else if (load) begin
            state             <= HOLD;
            wait_cnt          <= WW'(WAIT_CYCLES - 1);
            SC_POINT_WAIT_Out <= 1'b1;
        end else begin
            case (state)
                HOLD: begin
                    if (wait_cnt == '0) begin
                        state             <= IDLE;
                        SC_POINT_WAIT_Out <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: SC_POINT_WAIT_Out <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_sc_point_datapath.sv
// Bench for sc_point_datapath: directed scenarios plus random traffic against an arithmetic reference model.
module tb_sc_point_datapath;

    localparam int TICK_MAX    = 25;
    localparam int WAIT_CYCLES = 4;
    localparam int INIT        = 8'h10;
    localparam int CAR         = 8'h18;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear_n, load_n, psel, up_n;
    logic [1:0] shsel;
    logic [7:0] data;
    logic [7:0] point;
    logic [3:0] score;
    logic       t0_n, wait_o;

    int checks = 0;
    int passed = 0;

    int   m_pos, m_score, m_presc, m_wait;
    logic m_tick;

    always #10 clk = ~clk;

    sc_point_datapath #(
        .DATAWIDTH   (8),
        .INIT_POS    (8'h10),
        .CAR_PATTERN (8'h18),
        .TICK_MAX    (TICK_MAX),
        .WAIT_CYCLES (WAIT_CYCLES),
        .SCOREWIDTH  (4)
    ) dut (
        .SC_STATEMACHINEPOINT_CLOCK_50     (clk),
        .SC_STATEMACHINEPOINT_RESET_InHigh (rst),
        .SC_POINT_clear_InLow              (clear_n),
        .SC_POINT_load0_InLow              (load_n),
        .SC_POINT_POINTselection_In        (psel),
        .SC_POINT_shiftselection_In        (shsel),
        .SC_POINT_upcount_InLow            (up_n),
        .SC_POINT_data_In                  (data),
        .SC_POINT_point_Out                (point),
        .SC_POINT_score_Out                (score),
        .SC_POINT_T0_OutLow                (t0_n),
        .SC_POINT_WAIT_Out                 (wait_o)
    );

    task automatic model_reset();
        m_pos = INIT; m_score = 0; m_presc = 0; m_wait = 0; m_tick = 1'b1;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, settle 1 ns past it.
    task automatic step(input logic c, input logic l, input logic ps, input logic [1:0] sh,
                        input logic u, input logic [7:0] d);
        clear_n = c; load_n = l; psel = ps; shsel = sh; up_n = u; data = d;
        @(posedge clk);
        m_tick = 1'b1;
        if (!c) begin
            m_pos = INIT; m_score = 0; m_presc = 0; m_wait = 0;
        end else begin
            if (!u) begin
                if (m_presc == TICK_MAX - 1) begin m_presc = 0; m_tick = 1'b0; end
                else m_presc = m_presc + 1;
            end
            if (!l) begin
                m_pos  = ps ? CAR : int'(d);
                if (ps && m_score < 15) m_score = m_score + 1;
                m_wait = WAIT_CYCLES;
            end else begin
                if (sh == 2'b01) begin
                    if (m_pos >= 128) begin
`ifdef SC_POINT_WRAP_EN
                        m_pos = (m_pos * 2 + 1) % 256;
`endif
                    end else m_pos = m_pos * 2;
                end else if (sh == 2'b10) begin
                    if (m_pos % 2 == 1) begin
`ifdef SC_POINT_WRAP_EN
                        m_pos = m_pos / 2 + 128;
`endif
                    end else m_pos = m_pos / 2;
                end
                if (m_wait > 0) m_wait = m_wait - 1;
            end
        end
        #1;
    endtask

    task automatic idle();
        step(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 8'h00);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_n = 1'b1; load_n = 1'b1; psel = 1'b0; shsel = 2'b00; up_n = 1'b1; data = 8'h00;
        model_reset();
        #35;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (point !== 8'h10) $display("FAIL reset_point got %h want 10", point); else passed++;
        checks++; if (score !== 4'd0) $display("FAIL reset_score got %0d want 0", score); else passed++;
        checks++; if (t0_n !== 1'b1) $display("FAIL reset_t0 got %b want 1", t0_n); else passed++;
        checks++; if (wait_o !== 1'b0) $display("FAIL reset_wait got %b want 0", wait_o); else passed++;
    endtask

    task automatic test_shift();
        logic [7:0] want [4];
        want[0] = 8'h20; want[1] = 8'h40; want[2] = 8'h80;
`ifdef SC_POINT_WRAP_EN
        want[3] = 8'h01;
`else
        want[3] = 8'h80;
`endif
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 8'h00);
            checks++;
            if (point !== want[i] || point !== 8'(m_pos))
                $display("FAIL shift_left[%0d] got %h want %h", i, point, want[i]);
            else passed++;
        end
        step(1'b1, 1'b1, 1'b0, 2'b11, 1'b1, 8'h00);
        checks++; if (point !== want[3]) $display("FAIL shift_hold11 got %h want %h", point, want[3]); else passed++;
    endtask

    task automatic test_load();
        int high = 0;
        step(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 8'h05);
        checks++; if (point !== 8'h05) $display("FAIL load_data got %h want 05", point); else passed++;
        for (int i = 0; i < 8; i++) begin
            if (wait_o === 1'b1) high++;
            if (i < 4) begin
                checks++; if (wait_o !== 1'b1) $display("FAIL load_wait_high[%0d] got %b want 1", i, wait_o); else passed++;
            end
            idle();
        end
        checks++; if (high != 4) $display("FAIL load_wait_len got %0d want 4", high); else passed++;
        checks++; if (score !== 4'd0) $display("FAIL load_score got %0d want 0", score); else passed++;
    endtask

    task automatic test_tick();
        int lows = 0;
        step(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 8'h00);
        for (int i = 1; i <= 25; i++) begin
            step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
            if (t0_n === 1'b0) lows++;
            if (i == 25) begin
                checks++; if (t0_n !== 1'b0) $display("FAIL tick_after_25 got %b want 0", t0_n); else passed++;
            end
        end
        idle();
        checks++; if (t0_n !== 1'b1) $display("FAIL tick_width got %b want 1", t0_n); else passed++;
        checks++; if (lows != 1) $display("FAIL tick_count got %0d want 1", lows); else passed++;
        for (int i = 0; i < 25; i++) begin
            step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
            checks++; if (t0_n !== m_tick) $display("FAIL tick_wrap[%0d] got %b want %b", i, t0_n, m_tick); else passed++;
        end
    endtask

    task automatic test_score();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 8'h00);
        checks++; if (score !== 4'd15) $display("FAIL score_sat got %0d want 15", score); else passed++;
        checks++; if (point !== 8'h18) $display("FAIL score_point got %h want 18", point); else passed++;
        step(1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 8'h00);
        checks++; if (point !== 8'h10) $display("FAIL clrload_point got %h want 10", point); else passed++;
        checks++; if (score !== 4'd0) $display("FAIL clrload_score got %0d want 0", score); else passed++;
        checks++; if (wait_o !== 1'b0) $display("FAIL clrload_wait got %b want 0", wait_o); else passed++;
    endtask

    task automatic test_random();
        int errs = 0;
        logic c, l, ps, u;
        logic [1:0] sh;
        logic [7:0] d;
        for (int i = 0; i < 400; i++) begin
            c  = ($urandom_range(0, 19) != 0);
            l  = ($urandom_range(0, 5) != 0);
            ps = 1'($urandom_range(0, 1));
            sh = 2'($urandom_range(0, 3));
            u  = ($urandom_range(0, 3) == 0);
            d  = 8'($urandom_range(0, 255));
            step(c, l, ps, sh, u, d);
            if (point !== 8'(m_pos) || score !== 4'(m_score) || t0_n !== m_tick || wait_o !== (m_wait > 0)) begin
                checks++;
                errs++;
                if (errs <= 5)
                    $display("FAIL random[%0d] got p=%h s=%0d t=%b w=%b want p=%h s=%0d t=%b w=%b",
                             i, point, score, t0_n, wait_o, 8'(m_pos), m_score, m_tick, m_wait > 0);
            end else begin
                checks++; passed++;
            end
        end
    endtask

    task automatic test_async_reset();
        step(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 8'h00);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 8'h00);
        checks++; if (wait_o !== 1'b1 || point !== 8'h18) $display("FAIL pre_reset got w=%b p=%h want w=1 p=18", wait_o, point); else passed++;
        #4;
        rst = 1'b1;
        #1;
        model_reset();
        checks++; if (point !== 8'h10) $display("FAIL async_point got %h want 10", point); else passed++;
        checks++; if (score !== 4'd0) $display("FAIL async_score got %0d want 0", score); else passed++;
        checks++; if (wait_o !== 1'b0) $display("FAIL async_wait got %b want 0", wait_o); else passed++;
        checks++; if (t0_n !== 1'b1) $display("FAIL async_t0 got %b want 1", t0_n); else passed++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
            checks++; if (t0_n !== m_tick) $display("FAIL async_presc[%0d] got %b want %b", i, t0_n, m_tick); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_shift();
        test_load();
        test_tick();
        test_score();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sc_point_datapath.md
Name: sc_point_datapath

Overview:
- Datapath responder for the point/car control FSM. It consumes that FSM's active-low strobes and its selection codes.
- It owns the point-position shift register, the score counter and the move prescaler.
- It drives back the FSM's status inputs: the T0 move tick (active-low) and the WAIT hold flag.
- It sits between the control FSM and the LED/matrix display driver.

Parameters:
- DATAWIDTH, 8, width of the point-position register and of the load data.
- INIT_POS, 8'b0001_0000, one-hot position loaded by clear.
- CAR_PATTERN, 8'b0001_1000, pattern loaded when point selection is active.
- TICK_MAX, 25, number of upcount strobes per T0 tick (must be at least 2).
- WAIT_CYCLES, 4, clock cycles WAIT_Out stays high after a load (must be at least 1).
- SCOREWIDTH, 4, width of the score counter.

Ports:
- SC_STATEMACHINEPOINT_CLOCK_50, in, 1, system clock, 50 MHz, all state updates on posedge.
- SC_STATEMACHINEPOINT_RESET_InHigh, in, 1, asynchronous active-high reset.
- SC_POINT_clear_InLow, in, 1, clear strobe, active-low.
- SC_POINT_load0_InLow, in, 1, load strobe, active-low.
- SC_POINT_POINTselection_In, in, 1, load source: 0 = data_In, 1 = CAR_PATTERN.
- SC_POINT_shiftselection_In, in, 2, shift code: 01 = left, 10 = right, 00/11 = hold.
- SC_POINT_upcount_InLow, in, 1, prescaler increment strobe, active-low.
- SC_POINT_data_In, in, DATAWIDTH, external load value.
- SC_POINT_point_Out, out, DATAWIDTH, current position register.
- SC_POINT_score_Out, out, SCOREWIDTH, score counter.
- SC_POINT_T0_OutLow, out, 1, move tick, active-low, one cycle wide.
- SC_POINT_WAIT_Out, out, 1, hold request to the FSM.

Behaviour:
- Reset (asynchronous, on SC_STATEMACHINEPOINT_RESET_InHigh high; mid-operation reset aborts everything immediately):
  - point_Out = INIT_POS, score_Out = 0, prescaler = 0.
  - T0_OutLow = 1, WAIT_Out = 0, WAIT FSM = IDLE.
- Position register, evaluated each clock, priority clear > load > shift > hold:
  - clear low: point_Out <= INIT_POS.
  - load low: point_Out <= POINTselection ? CAR_PATTERN : data_In.
  - shift 01: logical shift toward MSB; hold if MSB already 1 (saturate, no bit loss).
  - shift 10: logical shift toward LSB; hold if LSB already 1.
  - shift 00/11: hold.
  - Each operation takes one-cycle latency; the result is visible the cycle after the strobe.
- Prescaler (mod TICK_MAX):
  - Increments on each cycle with upcount_InLow low.
  - On a strobe while the count is TICK_MAX-1: wraps to 0 and registers T0_OutLow = 0 for exactly the next cycle; otherwise T0_OutLow = 1.
  - Clear zeros the prescaler and suppresses a same-cycle tick.
  - A held upcount counts once per cycle.
- Score counter:
  - Increments on a load with POINTselection = 1.
  - Saturates at 2^SCOREWIDTH-1.
  - Clear zeros it.
  - Clear and load in the same cycle: clear wins, no increment.
- WAIT FSM, two states:
  - IDLE: WAIT_Out = 0. A load strobe moves to HOLD and sets the counter to WAIT_CYCLES-1.
  - HOLD: WAIT_Out = 1. The counter decrements each cycle; at 0 the FSM returns to IDLE.
  - A load strobe in HOLD restarts the counter.
  - Clear in HOLD returns to IDLE with WAIT_Out = 0 the next cycle.
  - WAIT_Out goes high the cycle after the load strobe and stays high exactly WAIT_CYCLES cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: SC_POINT_WRAP_EN.
- Defined: shifts rotate; the MSB wraps to the LSB on left shift and the LSB wraps to the MSB on right shift.
- Undefined: saturating shifts as specified above.
- No other behaviour changes.

Decomposition:
- Package sc_point_pkg holds:
  - Shift codes: SHIFT_LEFT = 2'b01, SHIFT_RIGHT = 2'b10, SHIFT_HOLD = 2'b11.
  - WAIT FSM state encodings: IDLE = 0, HOLD = 1.
  - Default INIT_POS and CAR_PATTERN constants.
- One sub-module, sc_point_prescaler: the mod-TICK_MAX counter with registered active-low tick and synchronous clear.

Test Plan:
- Reset then release -> point_Out = 8'h10, score_Out = 0, T0_OutLow = 1, WAIT_Out = 0.
- Three left-shift cycles from 8'h10 -> 8'h20, 8'h40, 8'h80; a fourth left shift holds 8'h80 (with SC_POINT_WRAP_EN: 8'h01).
- load0 low with POINTselection = 0 and data_In = 8'h05 -> point_Out = 8'h05 next cycle; WAIT_Out high for exactly 4 cycles starting the cycle after the strobe; score stays 0.
- 25 consecutive upcount strobes -> one T0_OutLow low pulse, one cycle wide, on the cycle after the 25th strobe; the prescaler wraps to 0.
- 16 loads with POINTselection = 1 -> score saturates at 15 and point_Out = 8'h18; clear and load in the same cycle -> point_Out = 8'h10, score = 0, WAIT_Out = 0.
- Reset asserted mid-HOLD with prescaler = 12 -> all outputs return to reset values immediately, without waiting for a clock edge.
